// File: rtl/des_key_sched.sv
// DES key schedule: turns a post-PC-1 key into a stream of PC-2 round keys.
// Handshake: a subkey transfers when subkey_valid && subkey_ready on a rising edge.
//   clk, rst        : clock, asynchronous active-high reset
//   key_in[55:0]    : C0||D0 (key_in[55] = PC-1 bit 1)
//   start, decrypt  : begin a run; decrypt=1 emits K16..K1
//   subkey[47:0]    : PC-2 of current C||D (subkey[47] = PC-2 bit 1), 0 when not valid
//   subkey_valid    : subkey holds a round key
//   subkey_ready    : consumer accepts the subkey
//   round[3:0]      : 0-based issue index of the presented subkey
//   busy, done      : run in progress / one-cycle pulse after the last transfer
module des_key_sched #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [55:0] key_in,
  input  logic        start,
  input  logic        decrypt,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  localparam int unsigned HALF_W = 28;
  localparam int unsigned KEY_W  = 56;
  localparam int unsigned SUB_W  = 48;
  localparam int unsigned RND_W  = 4;
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(ROUNDS - 1);

  // PC-2 selection, 1-based bit numbers of C||D (bit 1 = MSB)
  localparam int unsigned PC2_TAB [SUB_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, FINISH} state_t;

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   c_q, c_d, d_q, d_d;
  logic                dec_q, dec_d;
  logic [RND_W-1:0]    round_d;
  logic                valid_d, busy_d, done_d;

  // Encrypt left-shift amount applied before the round with 0-based index idx
  function automatic logic [1:0] enc_shift(input logic [RND_W-1:0] idx);
    return (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic [1:0] n);
    return (n == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic [1:0] n);
    return (n == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  function automatic logic [SUB_W-1:0] pc2(input logic [KEY_W-1:0] cd);
    logic [SUB_W-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < SUB_W; i++) begin
      k[SUB_W-1-i] = cd[KEY_W-PC2_TAB[i]];
    end
    return k;
  endfunction

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      c_q          <= '0;
      d_q          <= '0;
      dec_q        <= 1'b0;
      round        <= '0;
      subkey_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      d_q          <= d_d;
      dec_q        <= dec_d;
      round        <= round_d;
      subkey_valid <= valid_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // Next-state, key rotation and output logic
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    dec_d   = dec_q;
    round_d = round;
    valid_d = subkey_valid;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          c_d     = key_in[55:28];
          d_d     = key_in[27:0];
          dec_d   = decrypt;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        // Decrypt starts from C0||D0 itself, which equals C16||D16
        state_d = EMIT;
        valid_d = 1'b1;
        round_d = '0;
        if (!dec_q) begin
          c_d = rotl(c_q, enc_shift(4'd0));
          d_d = rotl(d_q, enc_shift(4'd0));
        end
      end
      EMIT: begin
        if (subkey_valid && subkey_ready) begin
          if (round == LAST_ROUND) begin
            state_d = FINISH;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            round_d = '0;
          end else begin
            round_d = round + 4'd1;
            // Decrypt undoes the encrypt shifts in reverse table order
            if (dec_q) begin
              c_d = rotr(c_q, enc_shift(4'd15 - round));
              d_d = rotr(d_q, enc_shift(4'd15 - round));
            end else begin
              c_d = rotl(c_q, enc_shift(round + 4'd1));
              d_d = rotl(d_q, enc_shift(round + 4'd1));
            end
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Subkey is combinational from the registered halves, gated to zero when idle
  always_comb begin
    subkey = '0;
    if (subkey_valid) begin
      subkey = pc2({c_q, d_q});
    end
  end

endmodule
